centroid_updater: RTL and testbench
===================================

Name: centroid_updater

Overview:
Update stage of the K-means engine, and the consumer of the 2-bit cluster ID produced by the assignment stage.
- Accepts labelled points (x, y, cluster_id) for one epoch and keeps a per-cluster sum and count.
- On the last point of the epoch, computes each new centroid as sum/count with a shared sequential divider.
- Publishes all three centroids with a one-cycle valid pulse; they feed back to the distance units for the next epoch.

Parameters:
COORD_W, 16, unsigned coordinate width.
CNT_W, 16, per-cluster point-count width; SUM_W = COORD_W + CNT_W (derived, not overridable).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pt_valid  in  1  point present
pt_ready  out  1  point accepted when pt_valid & pt_ready
pt_x  in  COORD_W  point x
pt_y  in  COORD_W  point y
pt_cluster_id  in  2  00=C1, 01=C2, 10=C3; 11 illegal
pt_last  in  1  qualifies final point of epoch
ld_en  in  1  preload one centroid
ld_sel  in  2  centroid select for preload (11 ignored)
ld_x  in  COORD_W  preload x
ld_y  in  COORD_W  preload y
c1_x, c1_y, c2_x, c2_y, c3_x, c3_y  out  COORD_W each  current centroids (registered)
cent_valid  out  1  one-cycle pulse: new centroids published
bad_id  out  1  sticky: point with id 11 seen
cnt_ovf  out  1  sticky: point dropped because its cluster count was at max

Behaviour:
- Reset (async assert, sync-released use): state=ACCUM, all sums/counts=0, all centroid outputs=0, cent_valid=0, bad_id=0, cnt_ovf=0, pt_ready=1.
- States: ACCUM, DIV, DONE. pt_ready = (state==ACCUM), combinational from state.
- ACCUM, per accepted point with id k in {00,01,10}:
  - if count[k] < 2^CNT_W-1: sum_x[k] += pt_x, sum_y[k] += pt_y, count[k] += 1;
  - else: point dropped, cnt_ovf <= 1.
- ACCUM, accepted point with id 11: dropped, bad_id <= 1.
- pt_last on an accepted point (dropped or not) -> DIV on the next edge. The final point is accumulated before dividing.
- ld_en is honoured only in ACCUM: the selected centroid output <= (ld_x, ld_y) next edge. It is independent of point acceptance in the same cycle. ld_en in DIV/DONE is ignored.
- DIV: six quotients computed in fixed order C1x, C1y, C2x, C2y, C3x, C3y by one restoring divider (1 bit/cycle, unsigned, floor).
  - Each quotient takes 1 load cycle + SUM_W iteration cycles.
  - Quotient is truncated to low COORD_W bits; it cannot exceed a coordinate because sum/count <= max coordinate.
  - Quotients are staged internally; centroid outputs do not change during DIV.
  - count[k]==0: quotient slot still consumes its cycles (fixed latency), and centroid k retains its previous value.
- DONE: one cycle. All six staged values are written to the outputs on the edge entering DONE, with cent_valid=1 during DONE. Sums/counts are cleared. Next state is ACCUM.
- Latency: cent_valid is high exactly 6*(SUM_W+1)+1 cycles after the edge that accepts the pt_last point.
- pt_valid during DIV/DONE is not accepted, and sums are unaffected (upstream must hold the point).
- bad_id and cnt_ovf clear only on reset.
- Reset mid-DIV/DONE aborts immediately: all state is returned to reset values and no cent_valid is issued.

Test Plan:
(COORD_W=8, CNT_W=8 for all scenarios, so SUM_W=16 and latency=103.)
1. Reset: hold rst_n=0 -> all centroids 0, cent_valid=0, flags 0, pt_ready=1; release -> pt_ready stays 1.
2. Epoch:
   - Stimulus: ld C3=(5,6). C1 points (10,20), (20,40), (31,61). C2 point (100,200) with pt_last.
   - Response: cent_valid exactly 103 cycles later; C1=(20,40) (61/3, 121/3 floored), C2=(100,200), C3=(5,6) unchanged (empty cluster).
3. Backpressure: hold pt_valid=1 with a C1 point through DIV -> pt_ready=0 for all 103 cycles and no accumulation; the point is accepted in the first ACCUM cycle after DONE and counted in the next epoch.
4. Illegal ID: point id 11 (50,50) plus C1 (8,8) with pt_last -> bad_id=1, C1=(8,8); the id-11 point is not reflected in any centroid.
5. Overflow: 256 points (1,1) to C2, the last with pt_last -> cnt_ovf=1, C2=(1,1) from 255 accumulated points.
6. Reset mid-DIV: assert rst_n=0 at DIV cycle 40 -> centroids 0 immediately, no cent_valid; a subsequent epoch produces correct results.

Source files
------------

// File: rtl/centroid_updater.sv
// K-means update stage: accumulates per-cluster sums/counts over an epoch,
// then divides with one shared restoring divider and publishes three centroids.
module centroid_updater #(
  parameter int COORD_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [COORD_W-1:0] pt_x,
  input  logic [COORD_W-1:0] pt_y,
  input  logic [1:0]         pt_cluster_id,
  input  logic               pt_last,
  input  logic               ld_en,
  input  logic [1:0]         ld_sel,
  input  logic [COORD_W-1:0] ld_x,
  input  logic [COORD_W-1:0] ld_y,
  output logic [COORD_W-1:0] c1_x,
  output logic [COORD_W-1:0] c1_y,
  output logic [COORD_W-1:0] c2_x,
  output logic [COORD_W-1:0] c2_y,
  output logic [COORD_W-1:0] c3_x,
  output logic [COORD_W-1:0] c3_y,
  output logic               cent_valid,
  output logic               bad_id,
  output logic               cnt_ovf
);
  localparam int SUM_W  = COORD_W + CNT_W;
  localparam int ITER_W = $clog2(SUM_W + 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(SUM_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {ACCUM = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;

  state_t              state;
  logic [2:0]          slot;
  logic [ITER_W-1:0]   iter;
  logic [SUM_W-1:0]    dvd;
  logic [CNT_W-1:0]    dvs;
  logic [CNT_W-1:0]    rem;

  logic [SUM_W-1:0]    sum_x [3];
  logic [SUM_W-1:0]    sum_y [3];
  logic [CNT_W-1:0]    count [3];
  logic [COORD_W-1:0]  cen_x [3];
  logic [COORD_W-1:0]  cen_y [3];
  logic [COORD_W-1:0]  pub   [6];
  logic [2:0]          ovf_hit;

  logic                accept;
  logic                slot_done;
  logic                publish;
  logic [SUM_W-1:0]    load_sum;
  logic [CNT_W-1:0]    load_cnt;
  logic [CNT_W:0]      trial;
  logic [CNT_W-1:0]    diff;
  logic                q_bit;
  logic [CNT_W-1:0]    rem_next;
  logic [SUM_W-1:0]    quo_next;

  assign pt_ready  = (state == ACCUM);
  assign accept    = pt_valid & pt_ready;
  assign slot_done = (state == DIV) && (iter == LAST_ITER);
  assign publish   = slot_done && (slot == 3'd5);

  // Slot order: C1x, C1y, C2x, C2y, C3x, C3y
  always_comb begin
    load_sum = '0;
    load_cnt = '0;
    case (slot)
      3'd0: begin load_sum = sum_x[0]; load_cnt = count[0]; end
      3'd1: begin load_sum = sum_y[0]; load_cnt = count[0]; end
      3'd2: begin load_sum = sum_x[1]; load_cnt = count[1]; end
      3'd3: begin load_sum = sum_y[1]; load_cnt = count[1]; end
      3'd4: begin load_sum = sum_x[2]; load_cnt = count[2]; end
      3'd5: begin load_sum = sum_y[2]; load_cnt = count[2]; end
      default: ;
    endcase
  end

  // One restoring step; the quotient shifts into the dividend register.
  always_comb begin
    trial    = {rem, dvd[SUM_W-1]};
    diff     = trial[CNT_W-1:0] - dvs;
    q_bit    = (trial >= {1'b0, dvs});
    rem_next = q_bit ? diff : trial[CNT_W-1:0];
    quo_next = {dvd[SUM_W-2:0], q_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      slot       <= 3'd0;
      iter       <= '0;
      dvd        <= '0;
      dvs        <= '0;
      rem        <= '0;
      cent_valid <= 1'b0;
      bad_id     <= 1'b0;
      cnt_ovf    <= 1'b0;
    end else begin
      cent_valid <= 1'b0;
      if (accept && (pt_cluster_id == 2'd3)) bad_id <= 1'b1;
      if (|ovf_hit) cnt_ovf <= 1'b1;
      case (state)
        ACCUM: begin
          if (accept && pt_last) begin
            state <= DIV;
            slot  <= 3'd0;
            iter  <= '0;
          end
        end
        DIV: begin
          if (iter == '0) begin
            dvd  <= load_sum;
            dvs  <= load_cnt;
            rem  <= '0;
            iter <= iter + 1'b1;
          end else begin
            dvd <= quo_next;
            rem <= rem_next;
            if (iter == LAST_ITER) begin
              iter <= '0;
              if (slot == 3'd5) begin
                state      <= DONE;
                cent_valid <= 1'b1;
              end else begin
                slot <= slot + 3'd1;
              end
            end else begin
              iter <= iter + 1'b1;
            end
          end
        end
        DONE:    state <= ACCUM;
        default: state <= ACCUM;
      endcase
    end
  end

  // Slots 0..4 are staged; slot 5 finishes on the publishing edge itself.
  for (genvar gi = 0; gi < 5; gi++) begin : g_stage
    logic [COORD_W-1:0] stage;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage <= '0;
      end else if (slot_done && (slot == 3'(gi))) begin
        stage <= quo_next[COORD_W-1:0];
      end
    end
    assign pub[gi] = stage;
  end
  assign pub[5] = quo_next[COORD_W-1:0];

  for (genvar gi = 0; gi < 3; gi++) begin : g_cluster
    logic               hit;
    logic [SUM_W-1:0]   sx;
    logic [SUM_W-1:0]   sy;
    logic [CNT_W-1:0]   cnt;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;

    assign hit         = accept && (pt_cluster_id == 2'(gi));
    assign ovf_hit[gi] = hit && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sx  <= '0;
        sy  <= '0;
        cnt <= '0;
      end else if (state == DONE) begin
        sx  <= '0;
        sy  <= '0;
        cnt <= '0;
      end else if (hit && (cnt != CNT_MAX)) begin
        sx  <= sx + SUM_W'(pt_x);
        sy  <= sy + SUM_W'(pt_y);
        cnt <= cnt + CNT_W'(1);
      end
    end

    // An empty cluster keeps its previous centroid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cx <= '0;
        cy <= '0;
      end else if (publish && (cnt != '0)) begin
        cx <= pub[2*gi];
        cy <= pub[2*gi+1];
      end else if ((state == ACCUM) && ld_en && (ld_sel == 2'(gi))) begin
        cx <= ld_x;
        cy <= ld_y;
      end
    end

    assign sum_x[gi] = sx;
    assign sum_y[gi] = sy;
    assign count[gi] = cnt;
    assign cen_x[gi] = cx;
    assign cen_y[gi] = cy;
  end

  assign c1_x = cen_x[0];
  assign c1_y = cen_y[0];
  assign c2_x = cen_x[1];
  assign c2_y = cen_y[1];
  assign c3_x = cen_x[2];
  assign c3_y = cen_y[2];

endmodule

// File: tb/tb_centroid_updater.sv
// Self-checking bench for centroid_updater: directed epochs plus random
// epochs compared against an arithmetic sum/count/divide model.
module tb_centroid_updater;
  localparam int CW = 8;
  localparam int NW = 8;
  localparam int CMAX = (1 << NW) - 1;
  localparam int LAT = 6 * (CW + NW + 1) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pt_valid = 1'b0;
  logic          pt_ready;
  logic [CW-1:0] pt_x = '0;
  logic [CW-1:0] pt_y = '0;
  logic [1:0]    pt_cluster_id = '0;
  logic          pt_last = 1'b0;
  logic          ld_en = 1'b0;
  logic [1:0]    ld_sel = '0;
  logic [CW-1:0] ld_x = '0;
  logic [CW-1:0] ld_y = '0;
  logic [CW-1:0] c1_x, c1_y, c2_x, c2_y, c3_x, c3_y;
  logic          cent_valid, bad_id, cnt_ovf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_sx[3], m_sy[3], m_cnt[3], m_cx[3], m_cy[3];
  bit m_bad, m_ovf;

  centroid_updater #(.COORD_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_cluster_id(pt_cluster_id), .pt_last(pt_last),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_x(ld_x), .ld_y(ld_y),
    .c1_x(c1_x), .c1_y(c1_y), .c2_x(c2_x), .c2_y(c2_y), .c3_x(c3_x), .c3_y(c3_y),
    .cent_valid(cent_valid), .bad_id(bad_id), .cnt_ovf(cnt_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] out_x(input int k);
    case (k)
      0: return c1_x;
      1: return c2_x;
      default: return c3_x;
    endcase
  endfunction

  function automatic logic [CW-1:0] out_y(input int k);
    case (k)
      0: return c1_y;
      1: return c2_y;
      default: return c3_y;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_sx[k] = 0; m_sy[k] = 0; m_cnt[k] = 0; m_cx[k] = 0; m_cy[k] = 0;
    end
    m_bad = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_add(input int x, input int y, input int id);
    if (id == 3) m_bad = 1'b1;
    else if (m_cnt[id] == CMAX) m_ovf = 1'b1;
    else begin
      m_sx[id] += x; m_sy[id] += y; m_cnt[id] += 1;
    end
  endtask

  task automatic model_publish();
    for (int k = 0; k < 3; k++) begin
      if (m_cnt[k] != 0) begin
        m_cx[k] = m_sx[k] / m_cnt[k];
        m_cy[k] = m_sy[k] / m_cnt[k];
      end
      m_sx[k] = 0; m_sy[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_c%0d_x", ph, k + 1), 32'(out_x(k)), 32'(m_cx[k]));
      check($sformatf("%s_c%0d_y", ph, k + 1), 32'(out_y(k)), 32'(m_cy[k]));
    end
    check({ph, "_bad_id"}, 32'(bad_id), 32'(m_bad));
    check({ph, "_cnt_ovf"}, 32'(cnt_ovf), 32'(m_ovf));
    $display("epoch %s: c1=(%0d,%0d) c2=(%0d,%0d) c3=(%0d,%0d) bad_id=%0b cnt_ovf=%0b",
             ph, c1_x, c1_y, c2_x, c2_y, c3_x, c3_y, bad_id, cnt_ovf);
  endtask

  task automatic load(input logic [1:0] sel, input logic [CW-1:0] x, input logic [CW-1:0] y);
    @(negedge clk);
    ld_en = 1'b1; ld_sel = sel; ld_x = x; ld_y = y;
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (sel != 2'd3) begin m_cx[sel] = int'(x); m_cy[sel] = int'(y); end
  endtask

  task automatic send_point(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic [1:0] id);
    @(negedge clk);
    pt_valid = 1'b1; pt_x = x; pt_y = y; pt_cluster_id = id; pt_last = 1'b0;
    @(posedge clk); #1;
    pt_valid = 1'b0;
    model_add(int'(x), int'(y), int'(id));
  endtask

  // Latency counts the accepting edge of the last point as cycle 1.
  task automatic finish_epoch(input string ph, input logic [CW-1:0] x, input logic [CW-1:0] y,
                              input logic [1:0] id, input bit hold,
                              input logic [CW-1:0] hx, input logic [CW-1:0] hy);
    int lat;
    int low;
    bit seen;
    @(negedge clk);
    pt_valid = 1'b1; pt_x = x; pt_y = y; pt_cluster_id = id; pt_last = 1'b1;
    @(posedge clk); #1;
    model_add(int'(x), int'(y), int'(id));
    pt_last = 1'b0;
    if (hold) begin
      pt_x = hx; pt_y = hy; pt_cluster_id = 2'd0;
    end else begin
      pt_valid = 1'b0;
    end
    lat = 1;
    low = (pt_ready === 1'b0) ? 1 : 0;
    seen = (cent_valid === 1'b1);
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (pt_ready === 1'b0) low++;
      if (cent_valid === 1'b1) seen = 1'b1;
    end
    check({ph, "_latency"}, 32'(lat), 32'(LAT));
    model_publish();
    check_all(ph);
    @(posedge clk); #1;
    check({ph, "_valid_pulse"}, 32'(cent_valid), 32'd0);
    check({ph, "_ready_after"}, 32'(pt_ready), 32'd1);
    if (hold) begin
      check({ph, "_ready_low_cycles"}, 32'(low), 32'(LAT));
      @(posedge clk); #1;
      pt_valid = 1'b0;
      model_add(int'(hx), int'(hy), 0);
    end
  endtask

  initial begin
    int seen_valid;
    logic [1:0] rid;
    model_reset();

    // 1. reset
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset_cent_valid", 32'(cent_valid), 32'd0);
    check("reset_pt_ready", 32'(pt_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_pt_ready", 32'(pt_ready), 32'd1);

    // 2. basic epoch with empty C3 keeping its preload
    load(2'd2, 8'd5, 8'd6);
    check("load_c3_x", 32'(c3_x), 32'd5);
    check("load_c3_y", 32'(c3_y), 32'd6);
    send_point(8'd10, 8'd20, 2'd0);
    send_point(8'd20, 8'd40, 2'd0);
    send_point(8'd31, 8'd61, 2'd0);
    finish_epoch("epoch", 8'd100, 8'd200, 2'd1, 1'b0, 8'd0, 8'd0);
    check("epoch_c1_x_direct", 32'(c1_x), 32'd20);
    check("epoch_c1_y_direct", 32'(c1_y), 32'd40);

    // 3. backpressure: C1 point held through DIV/DONE joins next epoch
    send_point(8'd7, 8'd9, 2'd1);
    finish_epoch("bp", 8'd30, 8'd30, 2'd2, 1'b1, 8'd12, 8'd14);
    finish_epoch("bp_next", 8'd16, 8'd18, 2'd0, 1'b0, 8'd0, 8'd0);
    check("bp_next_c1_x_direct", 32'(c1_x), 32'd14);

    // 4. illegal id
    send_point(8'd50, 8'd50, 2'd3);
    finish_epoch("bad_id", 8'd8, 8'd8, 2'd0, 1'b0, 8'd0, 8'd0);
    check("bad_id_direct", 32'(bad_id), 32'd1);

    // 5. count overflow on C2
    for (int i = 0; i < CMAX; i++) send_point(8'd1, 8'd1, 2'd1);
    finish_epoch("ovf", 8'd1, 8'd1, 2'd1, 1'b0, 8'd0, 8'd0);
    check("ovf_direct", 32'(cnt_ovf), 32'd1);

    // 6. reset during DIV
    send_point(8'd90, 8'd90, 2'd0);
    @(negedge clk);
    pt_valid = 1'b1; pt_x = 8'd70; pt_y = 8'd80; pt_cluster_id = 2'd2; pt_last = 1'b1;
    @(posedge clk); #1;
    pt_valid = 1'b0; pt_last = 1'b0;
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("abort");
    check("abort_cent_valid", 32'(cent_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      if (cent_valid === 1'b1) seen_valid++;
    end
    check("abort_no_valid", 32'(seen_valid), 32'd0);
    send_point(8'd3, 8'd4, 2'd0);
    send_point(8'd6, 8'd9, 2'd0);
    finish_epoch("after_abort", 8'd200, 8'd100, 2'd2, 1'b0, 8'd0, 8'd0);

    // random epochs
    for (int e = 0; e < 6; e++) begin
      int n;
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0)
          load(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        rid = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        send_point(8'($urandom), 8'($urandom), rid);
      end
      rid = 2'($urandom_range(0, 3));
      finish_epoch($sformatf("rand%0d", e), 8'($urandom), 8'($urandom), rid, 1'b0, 8'd0, 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
